mem_access_ctrl: RTL and testbench

- MEM-stage data-memory access controller between the EX_MEM pipeline register and the MEM_WB register.
- Takes load/store requests from EX_MEM and runs a request/acknowledge handshake with the data memory, which has variable latency.
- Aligns and extends sub-word load data and produces the load word that MEM_WB captures on data_i.
- Drives the global pipeline stall, including MEM_WB stall_i, while an access is outstanding.

---
 rtl/mem_access_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: load/store handshake with a variable-latency
// memory, sub-word store lane steering, load alignment/extension, and pipeline stall.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        memread_i,
    input  logic        memwrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

    function automatic logic access_illegal(input logic rd, input logic wr,
                                            input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad | (rd & wr);
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = 4'b0011 << lo;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] format_load(input logic [31:0] rd, input logic [1:0] lo,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        case (lo)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00:   d = {{24{~uns & b[7]}}, b};
            2'b01:   d = {{16{~uns & h[15]}}, h};
            default: d = rd;
        endcase
        return d;
    endfunction

    state_t      state_q;
    logic [31:0] addr_q;
    logic [1:0]  lo_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [15:0] cnt_q;
    logic [31:0] data_q;
    logic        bus_err_q;

    logic        access_s;
    logic        illegal_s;
    logic        accept_s;
    logic        timeout_s;
    logic [31:0] load_d;

    assign access_s  = memread_i | memwrite_i;
    assign illegal_s = access_s & access_illegal(memread_i, memwrite_i, size_i, addr_i[1:0]);
    assign accept_s  = (state_q == ST_IDLE) & access_s & ~illegal_s;
    assign timeout_s = TO_EN & (cnt_q == TO_LAST);
    assign load_d    = we_q ? 32'd0 : format_load(mem_rdata_i, lo_q, size_q, uns_q);

    // Stall and misalign are combinational so the pipeline freezes in the same cycle the access appears
    always_comb begin
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        if (rst_i) begin
            stall_o    = accept_s | (state_q == ST_BUSY);
            misalign_o = illegal_s;
        end else begin
            stall_o    = 1'b0;
            misalign_o = 1'b0;
        end
    end

    assign mem_req_o   = (state_q == ST_BUSY);
    assign mem_we_o    = (state_q == ST_BUSY) & we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign data_o      = data_q;
    assign bus_err_o   = bus_err_q;

    // Access FSM; data_q is only non-zero while in DONE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'd0;
            lo_q      <= 2'b00;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'd0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            cnt_q     <= 16'd0;
            data_q    <= 32'd0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bus_err_q <= 1'b0;
                    data_q    <= 32'd0;
                    if (accept_s) begin
                        state_q <= ST_BUSY;
                        addr_q  <= {addr_i[31:2], 2'b00};
                        lo_q    <= addr_i[1:0];
                        we_q    <= memwrite_i;
                        be_q    <= memwrite_i ? store_be(size_i, addr_i[1:0]) : 4'b1111;
                        wdata_q <= memwrite_i ? store_data(size_i, wdata_i) : 32'd0;
                        size_q  <= size_i;
                        uns_q   <= unsigned_i;
                        cnt_q   <= 16'd0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (mem_ack_i) begin
                        state_q   <= ST_DONE;
                        data_q    <= load_d;
                        bus_err_q <= 1'b0;
                    end else if (timeout_s) begin
                        state_q   <= ST_DONE;
                        data_q    <= 32'd0;
                        bus_err_q <= 1'b1;
                    end else begin
                        state_q   <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    data_q    <= 32'd0;
                    bus_err_q <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    data_q    <= 32'd0;
                    bus_err_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with hand-computed expectations.
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        memread_i, memwrite_i, unsigned_i, mem_ack_i;
    logic [31:0] addr_i, wdata_i, mem_rdata_i;
    logic [1:0]  size_i;
    logic        mem_req_o, mem_we_o, stall_o, misalign_o, bus_err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, data_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mwb_q;
    int          total = 0;
    int          bad = 0;
    int          n;

    always #5 clk_i = ~clk_i;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .memread_i(memread_i), .memwrite_i(memwrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .size_i(size_i), .unsigned_i(unsigned_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .data_o(data_o), .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    // MEM_WB stand-in: latches data_o whenever the pipeline is not stalled
    always @(posedge clk_i) begin
        if (!stall_o) mwb_q <= data_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_acc(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] sz, input logic uns);
        memread_i = rd; memwrite_i = wr; addr_i = a; wdata_i = wd; size_i = sz; unsigned_i = uns;
    endtask

    task automatic clr_acc();
        set_acc(1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    endtask

    // Enter BUSY, ack in the given BUSY cycle (1-based), return in DONE
    task automatic run_ack(input logic [31:0] rdata, input int delay);
        tick();
        repeat (delay - 1) tick();
        mem_ack_i = 1'b1; mem_rdata_i = rdata;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    endtask

    initial begin
        rst_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        clr_acc();
        #12;
        chk("rst_req", mem_req_o, 32'd0);
        chk("rst_we", mem_we_o, 32'd0);
        chk("rst_stall", stall_o, 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_mis", misalign_o, 32'd0);
        chk("rst_berr", bus_err_o, 32'd0);
        rst_i = 1'b1;
        tick();

        // word load 0x100, ack in 3rd BUSY cycle
        set_acc(1'b1, 1'b0, 32'h100, 32'd0, 2'b10, 1'b0);
        #1; n = int'(stall_o);
        tick();
        chk("lw_req", mem_req_o, 32'd1);
        chk("lw_be", mem_be_o, 32'hF);
        chk("lw_addr", mem_addr_o, 32'h100);
        chk("lw_we", mem_we_o, 32'd0);
        n += int'(stall_o);
        tick(); n += int'(stall_o);
        tick(); n += int'(stall_o);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        chk("lw_stall_cycles", n, 32'd4);
        chk("lw_done_stall", stall_o, 32'd0);
        chk("lw_done_data", data_o, 32'hDEADBEEF);
        chk("lw_done_req", mem_req_o, 32'd0);
        clr_acc();
        tick();
        chk("lw_memwb", mwb_q, 32'hDEADBEEF);
        chk("lw_idle_data", data_o, 32'd0);

        // lb / lbu / lh
        set_acc(1'b1, 1'b0, 32'h103, 32'd0, 2'b00, 1'b0);
        run_ack(32'h80FF00FF, 1);
        chk("lb", data_o, 32'hFFFFFF80);
        clr_acc(); tick();
        set_acc(1'b1, 1'b0, 32'h103, 32'd0, 2'b00, 1'b1);
        run_ack(32'h80FF00FF, 1);
        chk("lbu", data_o, 32'h00000080);
        clr_acc(); tick();
        set_acc(1'b1, 1'b0, 32'h102, 32'd0, 2'b01, 1'b0);
        run_ack(32'h80FF1234, 2);
        chk("lh", data_o, 32'hFFFF80FF);
        clr_acc(); tick();

        // sb / sh
        set_acc(1'b0, 1'b1, 32'h201, 32'h000000AB, 2'b00, 1'b0);
        tick();
        chk("sb_addr", mem_addr_o, 32'h200);
        chk("sb_be", mem_be_o, 32'h2);
        chk("sb_wdata", mem_wdata_o, 32'hABABABAB);
        chk("sb_we", mem_we_o, 32'd1);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        chk("sb_done_data", data_o, 32'd0);
        clr_acc(); tick();
        set_acc(1'b0, 1'b1, 32'h202, 32'h00001234, 2'b01, 1'b0);
        tick();
        chk("sh_be", mem_be_o, 32'hC);
        chk("sh_wdata", mem_wdata_o, 32'h12341234);
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        clr_acc(); tick();

        // illegal accesses
        set_acc(1'b1, 1'b0, 32'h102, 32'd0, 2'b10, 1'b0);
        #1;
        chk("mis_w_flag", misalign_o, 32'd1);
        chk("mis_w_stall", stall_o, 32'd0);
        tick();
        chk("mis_w_req", mem_req_o, 32'd0);
        set_acc(1'b1, 1'b1, 32'h100, 32'd0, 2'b10, 1'b0);
        #1;
        chk("rdwr_flag", misalign_o, 32'd1);
        chk("rdwr_stall", stall_o, 32'd0);
        tick();
        chk("rdwr_req", mem_req_o, 32'd0);
        clr_acc(); tick();

        // timeout with no ack
        set_acc(1'b1, 1'b0, 32'h100, 32'd0, 2'b10, 1'b0);
        #1; n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!stall_o) break;
            n++;
            tick();
        end
        chk("to_stall_cycles", n, 32'd5);
        chk("to_berr", bus_err_o, 32'd1);
        chk("to_data", data_o, 32'd0);
        clr_acc(); tick();
        chk("to_berr_pulse", bus_err_o, 32'd0);
        chk("to_idle_req", mem_req_o, 32'd0);
        chk("to_idle_stall", stall_o, 32'd0);

        // reset mid-BUSY, then a stray ack
        set_acc(1'b1, 1'b0, 32'h104, 32'd0, 2'b10, 1'b0);
        tick();
        chk("rb_req", mem_req_o, 32'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("rb_req_drop", mem_req_o, 32'd0);
        chk("rb_stall_drop", stall_o, 32'd0);
        clr_acc();
        @(negedge clk_i);
        rst_i = 1'b1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        chk("stray_data", data_o, 32'd0);
        chk("stray_req", mem_req_o, 32'd0);
        tick();
        chk("stray_data2", data_o, 32'd0);
        chk("stray_stall", stall_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
